mouse_receiver: RTL

//  Device-to-host half of the PS/2 mouse link; counterpart of the mouse transmitter.

---
 rtl/mouse_receiver_if.sv | 20 ++
 rtl/mouse_receiver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mouse_receiver_if.sv
// Receive-side signal bundle for the PS/2 mouse link: raw pins and the enable from
// the mouse master, plus the byte/strobe/error results returned to that master.
interface mouse_receiver_if;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic       BYTE_READ;
  logic [7:0] BYTE;
  logic [1:0] BYTE_ERROR_CODE;

  modport slave (
    input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
    output BYTE_READ, BYTE, BYTE_ERROR_CODE
  );

  modport master (
    output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
    input  BYTE_READ, BYTE, BYTE_ERROR_CODE
  );
endinterface

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host deserialiser: samples 11-bit frames on mouse-clock falling edges
// and hands each byte plus parity/stop error flags to the master with a one-cycle strobe.
module mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  mouse_receiver_if.slave  bus
);

  localparam int             TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TIMER_TERM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    DATA   = 5'b00010,
    PARITY = 5'b00100,
    STOP   = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      clk_dly_q, clk_dly_d;
  logic [1:0]      data_dly_q, data_dly_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            perr_q, perr_d;
  logic            serr_q, serr_d;
  logic [7:0]      byte_q, byte_d;
  logic [1:0]      err_q, err_d;
  logic            byte_read_q, byte_read_d;

  logic            fall_s;
  logic            sampled_s;

  assign fall_s    = clk_dly_q[2] & ~clk_dly_q[1];
  assign sampled_s = data_dly_q[1];

  assign bus.BYTE_READ       = byte_read_q;
  assign bus.BYTE            = byte_q;
  assign bus.BYTE_ERROR_CODE = err_q;

  // Synchronisers, frame FSM and result capture.
  always_comb begin
    state_d     = state_q;
    clk_dly_d   = {clk_dly_q[1:0], bus.CLK_MOUSE_IN};
    data_dly_d  = {data_dly_q[0], bus.DATA_MOUSE_IN};
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    shreg_d     = shreg_q;
    perr_d      = perr_q;
    serr_d      = serr_q;
    byte_d      = byte_q;
    err_d       = err_q;
    byte_read_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall_s && bus.READ_ENABLE && !sampled_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end

      DATA, PARITY, STOP: begin
        // A fall beats an expiring timer; an enable drop beats both.
        if (!bus.READ_ENABLE) begin
          state_d = IDLE;
        end else if (fall_s) begin
          timer_d = '0;
          case (state_q)
            DATA: begin
              shreg_d   = {sampled_s, shreg_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_d = PARITY;
              end else begin
                state_d = DATA;
              end
            end
            PARITY: begin
              perr_d  = (sampled_s != ~^shreg_q);
              state_d = STOP;
            end
            STOP: begin
              // Results are loaded on entry to DONE so they are valid alongside the strobe.
              serr_d      = (sampled_s != 1'b1);
              byte_d      = shreg_q;
              err_d       = {(sampled_s != 1'b1), perr_q};
              byte_read_d = 1'b1;
              state_d     = DONE;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else if (timer_q == TIMER_TERM) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end

      DONE: begin
        timer_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; sync stages rest at the idle-high line level.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      clk_dly_q   <= 3'b111;
      data_dly_q  <= 2'b11;
      bit_cnt_q   <= 3'd0;
      timer_q     <= '0;
      shreg_q     <= 8'h00;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      byte_q      <= 8'h00;
      err_q       <= 2'b00;
      byte_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_dly_q   <= clk_dly_d;
      data_dly_q  <= data_dly_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      shreg_q     <= shreg_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
      byte_q      <= byte_d;
      err_q       <= err_d;
      byte_read_q <= byte_read_d;
    end
  end

endmodule
